// File: rtl/stream_rr_arbiter.sv
// Two-input packet-level round-robin stream arbiter with a single forward output register.
// Ownership is granted per packet and released only after the owner's last beat is accepted.
module stream_rr_arbiter #(
  parameter int DATA_WD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a_valid,
  input  logic [DATA_WD-1:0] a_data,
  input  logic               a_last,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [DATA_WD-1:0] b_data,
  input  logic               b_last,
  output logic               b_ready,
  output logic               c_valid,
  output logic [DATA_WD-1:0] c_data,
  output logic               c_last,
  input  logic               c_ready,
  output logic [1:0]         grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               lsv_q, lsv_d;  // last served: 0 = A, 1 = B
  logic               slot_free;
  logic               a_fire, b_fire, own_fire, own_last;
  logic [DATA_WD-1:0] own_data;

  assign slot_free = !c_valid || c_ready;
  assign a_ready   = (state_q == OWN_A) && slot_free;
  assign b_ready   = (state_q == OWN_B) && slot_free;
  assign a_fire    = a_valid && a_ready;
  assign b_fire    = b_valid && b_ready;
  assign own_fire  = a_fire || b_fire;
  assign own_data  = (state_q == OWN_B) ? b_data : a_data;
  assign own_last  = (state_q == OWN_B) ? b_last : a_last;
  assign grant     = {state_q == OWN_B, state_q == OWN_A};

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    lsv_d   = lsv_q;
    case (state_q)
      IDLE: begin
        if (a_valid && b_valid) state_d = lsv_q ? OWN_A : OWN_B;
        else if (a_valid)       state_d = OWN_A;
        else if (b_valid)       state_d = OWN_B;
      end
      OWN_A: begin
        if (a_fire && a_last) begin
          lsv_d   = 1'b0;
          state_d = b_valid ? OWN_B : IDLE;
        end
      end
      OWN_B: begin
        if (b_fire && b_last) begin
          lsv_d   = 1'b1;
          state_d = a_valid ? OWN_A : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lsv_q   <= 1'b1;  // A wins the first tie after reset
    end else begin
      state_q <= state_d;
      lsv_q   <= lsv_d;
    end
  end

  // Forward register: payload only moves on an owner fire, so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid <= 1'b0;
      c_data  <= '0;
      c_last  <= 1'b0;
    end else if (own_fire) begin
      c_valid <= 1'b1;
      c_data  <= own_data;
      c_last  <= own_last;
    end else if (c_ready) begin
      c_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: directed scenarios plus randomized traffic
// with a queue scoreboard fed at input handshakes and drained by an output monitor.
module tb_stream_rr_arbiter;

  localparam int DW = 8;  // bit 7 tags the source (0 = A, 1 = B)

  logic          clk, rst_n;
  logic          a_valid, a_last, a_ready;
  logic [DW-1:0] a_data;
  logic          b_valid, b_last, b_ready;
  logic [DW-1:0] b_data;
  logic          c_valid, c_last, c_ready;
  logic [DW-1:0] c_data;
  logic [1:0]    grant;

  int n_cmp = 0;
  int n_err = 0;

  stream_rr_arbiter #(.DATA_WD(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .c_valid(c_valid), .c_data(c_data), .c_last(c_last), .c_ready(c_ready),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: beats accepted at the inputs, in per-source order.
  logic [DW:0] q_a[$];
  logic [DW:0] q_b[$];
  int          out_src = -1;
  logic        in_a = 1'b0, in_b = 1'b0;
  logic        hold_q = 1'b0;
  logic [DW:0] hold_beat;

  always @(negedge clk) begin : monitor
    int          src;
    logic [DW:0] e;
    if (!rst_n) begin
      q_a.delete();
      q_b.delete();
      out_src = -1;
      in_a    = 1'b0;
      in_b    = 1'b0;
      hold_q  = 1'b0;
    end else begin
      check("grant_legal", grant == 2'b11, 1'b0);
      check("a_ready_rule", a_ready, (grant == 2'b01) && (!c_valid || c_ready));
      check("b_ready_rule", b_ready, (grant == 2'b10) && (!c_valid || c_ready));
      if (hold_q) begin
        check("c_hold_valid", c_valid, 1'b1);
        check("c_hold_beat", {c_last, c_data}, hold_beat);
      end
      if (in_a) check("own_hold_a", grant, 2'b01);
      if (in_b) check("own_hold_b", grant, 2'b10);
      if (a_valid && a_ready) begin
        q_a.push_back({a_last, a_data});
        in_a = !a_last;
      end
      if (b_valid && b_ready) begin
        q_b.push_back({b_last, b_data});
        in_b = !b_last;
      end
      if (c_valid && c_ready) begin
        src = int'(c_data[DW-1]);
        if (out_src >= 0) check("no_interleave", src, out_src);
        if (src == 0) begin
          if (q_a.size() == 0) check("c_beat_a_expected", 0, 1);
          else begin
            e = q_a.pop_front();
            check("c_beat_a", {c_last, c_data}, e);
          end
        end else begin
          if (q_b.size() == 0) check("c_beat_b_expected", 0, 1);
          else begin
            e = q_b.pop_front();
            check("c_beat_b", {c_last, c_data}, e);
          end
        end
        out_src = c_last ? -1 : src;
      end
      hold_q    = c_valid && !c_ready;
      hold_beat = {c_last, c_data};
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Random traffic generator state
  logic [6:0] a_seq = '0, b_seq = '0;
  int         a_rem = 0, b_rem = 0;
  logic       fa, fb, drained;

  task automatic drive_sources(input logic rand_valid);
    if (a_rem == 0 && rand_valid && $urandom_range(0, 3) != 0) a_rem = $urandom_range(1, 4);
    if (b_rem == 0 && rand_valid && $urandom_range(0, 3) != 0) b_rem = $urandom_range(1, 4);
    a_valid = (a_rem != 0) && (!rand_valid || $urandom_range(0, 3) != 0);
    b_valid = (b_rem != 0) && (!rand_valid || $urandom_range(0, 3) != 0);
    a_data  = {1'b0, a_seq};
    a_last  = (a_rem == 1);
    b_data  = {1'b1, b_seq};
    b_last  = (b_rem == 1);
  endtask

  initial begin : stimulus
    rst_n = 1'b0; c_ready = 1'b1;
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0;
    repeat (3) tick();
    check("rst_c_valid", c_valid, 1'b0);
    check("rst_c_data", c_data, 8'h00);
    check("rst_c_last", c_last, 1'b0);
    check("rst_grant", grant, 2'b00);
    check("rst_readies", {a_ready, b_ready}, 2'b00);

    // Both valid from reset, 3-beat packets: A first, then B with no idle bubble.
    a_valid = 1'b1; a_data = 8'h00; a_last = 1'b0;
    b_valid = 1'b1; b_data = 8'h80; b_last = 1'b0;
    rst_n = 1'b1;
    #1;
    check("idle_grant", grant, 2'b00);
    check("idle_readies", {a_ready, b_ready}, 2'b00);
    tick();
    check("first_grant", grant, 2'b01);
    check("first_a_ready", a_ready, 1'b1);
    check("first_c_valid", c_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      a_data = 8'(i); a_last = (i == 2);
      tick();
      check("t1_a_beat", {c_valid, c_last, c_data}, {1'b1, i == 2, 8'(i)});
      check("t1_grant", grant, (i == 2) ? 2'b10 : 2'b01);
    end
    a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_data = 8'h80 + 8'(i); b_last = (i == 2);
      tick();
      check("t1_b_beat", {c_valid, c_last, c_data}, {1'b1, i == 2, 8'h80 + 8'(i)});
      check("t1_b_grant", grant, (i == 2) ? 2'b00 : 2'b10);
    end
    b_valid = 1'b0;
    tick();
    check("t1_drain", c_valid, 1'b0);

    // Only A, single-beat packets: OWN_A / IDLE alternation.
    a_valid = 1'b1; a_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_data = 8'h10 + 8'(k);
      tick();
      check("t2_own", grant, 2'b01);
      check("t2_b_ready", b_ready, 1'b0);
      tick();
      check("t2_idle", grant, 2'b00);
      check("t2_beat", {c_valid, c_data}, {1'b1, 8'h10 + 8'(k)});
    end
    a_valid = 1'b0;
    tick();

    // A owns mid-packet and stalls while B waits.
    a_valid = 1'b1; a_data = 8'h20; a_last = 1'b0;
    tick();
    check("t3_own", grant, 2'b01);
    tick();
    check("t3_beat0", c_data, 8'h20);
    a_valid = 1'b0; b_valid = 1'b1; b_data = 8'h90; b_last = 1'b1;
    repeat (4) begin
      tick();
      check("t3_hold_grant", grant, 2'b01);
      check("t3_b_ready", b_ready, 1'b0);
    end
    a_valid = 1'b1; a_data = 8'h21; a_last = 1'b1;
    tick();
    check("t3_handover", grant, 2'b10);
    check("t3_beat1", {c_last, c_data}, {1'b1, 8'h21});
    a_valid = 1'b0;
    tick();
    check("t3_b_done", grant, 2'b00);
    check("t3_b_beat", c_data, 8'h90);
    b_valid = 1'b0;
    tick();

    // Output backpressure holds the beat.
    a_valid = 1'b1; a_data = 8'h07; a_last = 1'b0;
    tick();
    tick();
    check("t4_beat", c_data, 8'h07);
    c_ready = 1'b0; a_data = 8'h08; a_last = 1'b1;
    #1;
    check("t4_stall_ready", a_ready, 1'b0);
    repeat (5) begin
      tick();
      check("t4_hold", {c_valid, c_data, a_ready, grant}, {1'b1, 8'h07, 1'b0, 2'b01});
    end
    c_ready = 1'b1;
    #1;
    check("t4_release_ready", a_ready, 1'b1);
    tick();
    check("t4_next", {c_valid, c_last, c_data, grant}, {1'b1, 1'b1, 8'h08, 2'b00});
    a_valid = 1'b0;
    tick();
    check("t4_drain", c_valid, 1'b0);

    // Reset in the middle of a B packet, then A wins the tie again.
    b_valid = 1'b1; b_data = 8'hA0; b_last = 1'b0;
    tick();
    tick();
    check("t5_b_own", grant, 2'b10);
    b_data = 8'hA1;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_outs", {c_valid, c_data, c_last}, {1'b0, 8'h00, 1'b0});
    check("t5_rst_ctl", {grant, a_ready, b_ready}, 4'b0000);
    a_valid = 1'b1; a_data = 8'h30; a_last = 1'b1;
    b_data = 8'hA2; b_last = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    check("t5_idle", grant, 2'b00);
    tick();
    check("t5_a_first", grant, 2'b01);
    tick();
    check("t5_to_b", {grant, c_data}, {2'b10, 8'h30});
    a_valid = 1'b0;
    tick();
    check("t5_b_beat", {grant, c_data, c_last}, {2'b00, 8'hA2, 1'b1});
    b_valid = 1'b0;
    tick();

    // Randomized traffic and backpressure.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      fa = a_valid && a_ready;
      fb = b_valid && b_ready;
      tick();
      if (fa) begin a_seq++; a_rem--; end
      if (fb) begin b_seq++; b_rem--; end
      drive_sources(1'b1);
      c_ready = ($urandom_range(0, 9) < 7);
    end

    // Finish open packets and empty the output register.
    drained = 1'b0;
    for (int k = 0; k < 200 && !drained; k++) begin
      @(negedge clk);
      fa = a_valid && a_ready;
      fb = b_valid && b_ready;
      tick();
      if (fa) begin a_seq++; a_rem--; end
      if (fb) begin b_seq++; b_rem--; end
      drive_sources(1'b0);
      c_ready = 1'b1;
      drained = (a_rem == 0) && (b_rem == 0) && !c_valid;
    end
    @(negedge clk);
    #1;
    check("drain_done", drained, 1'b1);
    check("q_a_empty", q_a.size(), 0);
    check("q_b_empty", q_b.size(), 0);
    check("final_grant", grant, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 The module SHALL have one parameter: DATA_WD, default 4, width of every data bus.
REQ-002 The module SHALL have these ports:
  clk      in   1        clock, all logic on the rising edge
  rst_n    in   1        reset, asynchronous, active-low
  a_valid  in   1        requester A beat valid
  a_data   in   DATA_WD  requester A payload
  a_last   in   1        requester A final beat of packet
  a_ready  out  1        requester A beat accepted
  b_valid  in   1        requester B beat valid
  b_data   in   DATA_WD  requester B payload
  b_last   in   1        requester B final beat of packet
  b_ready  out  1        requester B beat accepted
  c_valid  out  1        output beat valid
  c_data   out  DATA_WD  output payload
  c_last   out  1        output final beat of packet
  c_ready  in   1        output sink ready
  grant    out  2        current owner, one-hot: 01 = A, 10 = B, 00 = none
REQ-003 Reset rst_n SHALL be asynchronous, active-low; clock clk.

Function
REQ-004 A fire on any port SHALL be valid && ready on the same rising edge.
REQ-005 The arbiter SHALL be a 3-state FSM: IDLE, OWN_A, OWN_B, plus a last-served bit lsv (0 = A, 1 = B).
REQ-006 IDLE: a_valid only -> OWN_A; b_valid only -> OWN_B; both -> owner is the requester not equal to lsv; neither -> stay IDLE.
REQ-007 In IDLE, a_ready and b_ready SHALL both be 0; the grant decision costs exactly one cycle.
REQ-008 grant SHALL be 01 in OWN_A, 10 in OWN_B, 00 in IDLE.
REQ-009 slot_free SHALL be (!c_valid || c_ready); a_ready = (state==OWN_A) && slot_free; b_ready = (state==OWN_B) && slot_free.
REQ-010 The non-owner's ready SHALL never be asserted.
REQ-011 Output stage SHALL be a single forward register: on owner fire, c_data/c_last <= owner data/last and c_valid <= 1; else if c_ready, c_valid <= 0; c_data/c_last hold when no owner fire occurs.
REQ-012 Latency input fire -> c_valid SHALL be 1 cycle; with c_ready held 1, throughput SHALL be one beat per cycle within a packet.
REQ-013 c_valid/c_data/c_last SHALL remain stable while c_valid && !c_ready.
REQ-014 Ownership SHALL be held for the whole packet; owner valid dropping mid-packet keeps the state unchanged (no re-arbitration).
REQ-015 On owner fire with last=1: lsv <= owner; next state = OWN_other if other_valid is 1 that cycle, else IDLE.
REQ-016 A single-beat packet (last=1 on first beat) SHALL follow REQ-015 identically.
REQ-017 Owner fire with last=0 SHALL keep the state.
REQ-018 Non-owner input signals SHALL have no effect on outputs or state except via REQ-006/REQ-015.
REQ-019 Payload SHALL pass unmodified, bit-exact, DATA_WD wide.

Reset
REQ-020 On rst_n low: state = IDLE, lsv = 1 (A wins first tie), c_valid = 0, c_data = 0, c_last = 0, grant = 00, a_ready = b_ready = 0.
REQ-021 Reset asserted mid-packet SHALL abandon the packet; after release, arbitration restarts from REQ-020 values with no partial-packet memory.
REQ-022 The first arbitration decision SHALL occur on the first rising clk edge with rst_n high.

Verification
REQ-023 Both valid from reset, 3-beat packets, c_ready=1 -> grant 01 for 3 ready cycles, A beats 0,1,2 on c_data cycles +1, then grant 10 with no IDLE bubble.
REQ-024 Only A valid, single-beat packets back-to-back -> pattern OWN_A, IDLE, OWN_A, ...; one beat per 2 cycles; b_ready stays 0.
REQ-025 A owns mid-packet, a_valid drops 4 cycles while b_valid=1 -> grant stays 01, b_ready stays 0; A resumes, finishes, then B granted.
REQ-026 c_ready=0 for 5 cycles with c_valid=1, c_data=4'h7 -> c_data holds 4'h7, owner ready 0, no beat lost or duplicated.
REQ-027 rst_n pulsed low during B packet beat 2 -> all outputs reset values immediately; after release with both valid, A granted first.
REQ-028 Random valid/ready, 2000 cycles -> scoreboard: per-source order preserved, packets never interleaved on c, every c_last matches source last.
